// File: rtl/lstm_cfg_sequencer.sv
// lstm_cfg_sequencer
//   Loads the coefficient set of an LSTM stack through a valid/ready word port,
//   then gates the upstream sample stream into the stack while tracking how many
//   samples are still inside it. A reload request drains the stack before the
//   new coefficient set starts loading.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_start           request to (re)load coefficients
//   cfg_data/valid      coefficient word stream; cfg_ready accepts a word
//   cfg_busy            LOAD or DRAIN in progress
//   cfg_done            full coefficient set loaded, datapath enabled
//   weight_x/h, bias_x/h
//                       LAYERS*4 words each, index = layer*4 + gate
//   s_x/valid/ready     upstream sample handshake
//   dp_x_in/valid       sample forwarded to the stack (zero latency)
//   dp_ready, dp_valid  stack ready / one result per accepted sample
//   inflight            samples accepted but not yet returned
//   err                 sticky: result returned with nothing in flight
module lstm_cfg_sequencer #(
  parameter int LAYERS       = 3,
  parameter int WIDTH        = 16,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic [WIDTH-1:0]                    cfg_data,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  output logic                                cfg_busy,
  output logic                                cfg_done,
  output logic [LAYERS*4-1:0][WIDTH-1:0]      weight_x,
  output logic [LAYERS*4-1:0][WIDTH-1:0]      weight_h,
  output logic [LAYERS*4-1:0][WIDTH-1:0]      bias_x,
  output logic [LAYERS*4-1:0][WIDTH-1:0]      bias_h,
  input  logic [WIDTH-1:0]                    s_x,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [WIDTH-1:0]                    dp_x_in,
  output logic                                dp_x_in_valid,
  input  logic                                dp_ready,
  input  logic                                dp_valid,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
  output logic                                err
);

  localparam int TOTAL = LAYERS*16;
  localparam int N     = LAYERS*4;
  localparam int CW    = $clog2(TOTAL);
  localparam int IW    = $clog2(MAX_INFLIGHT+1);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          wr;

  // Handshake outputs are decoded from state; rst masks them in the same cycle.
  assign cfg_ready     = ~rst & (state == LOAD);
  assign cfg_busy      = ~rst & ((state == LOAD) | (state == DRAIN));
  // cfg_start closes the sample gate immediately so nothing slips in as we leave ACTIVE.
  assign s_ready       = ~rst & (state == ACTIVE) & dp_ready &
                         (inflight < IW'(MAX_INFLIGHT)) & ~cfg_start;
  assign dp_x_in       = s_x;
  assign dp_x_in_valid = s_valid & s_ready;

  assign acc = s_valid & s_ready;
  assign wr  = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      inflight <= '0;
      err      <= 1'b0;
      cfg_done <= 1'b0;
      weight_x <= '0;
      weight_h <= '0;
      bias_x   <= '0;
      bias_h   <= '0;
    end else begin
      // Accept and return in the same cycle cancel out.
      if (acc && !dp_valid) begin
        inflight <= inflight + IW'(1);
      end else if (!acc && dp_valid) begin
        if (inflight == '0) err <= 1'b1;
        else                inflight <= inflight - IW'(1);
      end

      case (state)
        IDLE: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (wr) begin
            // Banks are laid out back to back in the word stream.
            for (int i = 0; i < N; i++) begin
              if (cnt == CW'(i))       weight_x[i] <= cfg_data;
              if (cnt == CW'(N + i))   weight_h[i] <= cfg_data;
              if (cnt == CW'(2*N + i)) bias_x[i]   <= cfg_data;
              if (cnt == CW'(3*N + i)) bias_h[i]   <= cfg_data;
            end
            if (cnt == CW'(TOTAL-1)) begin
              state    <= ACTIVE;
              cfg_done <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ACTIVE: begin
          if (cfg_start) state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0) begin
            state    <= LOAD;
            cnt      <= '0;
            cfg_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_cfg_sequencer.sv
module tb_lstm_cfg_sequencer;
  localparam int LAYERS = 3;
  localparam int WIDTH  = 16;
  localparam int N      = LAYERS*4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         cfg_start, cfg_valid;
  logic [WIDTH-1:0]             cfg_data;
  logic                         cfg_ready, cfg_busy, cfg_done;
  logic [N-1:0][WIDTH-1:0]      weight_x, weight_h, bias_x, bias_h;
  logic [WIDTH-1:0]             s_x, dp_x_in;
  logic                         s_valid, s_ready, dp_x_in_valid;
  logic                         dp_ready, dp_valid;
  logic [3:0]                   inflight;
  logic                         err;

  int checks = 0;
  int errors = 0;
  int accs;

  always #5 clk = ~clk;

  lstm_cfg_sequencer #(.LAYERS(LAYERS), .WIDTH(WIDTH), .MAX_INFLIGHT(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .weight_x(weight_x), .weight_h(weight_h), .bias_x(bias_x), .bias_h(bias_h),
    .s_x(s_x), .s_valid(s_valid), .s_ready(s_ready),
    .dp_x_in(dp_x_in), .dp_x_in_valid(dp_x_in_valid),
    .dp_ready(dp_ready), .dp_valid(dp_valid),
    .inflight(inflight), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs driven after this settle before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic coef_zero();
    return (weight_x == '0) && (weight_h == '0) && (bias_x == '0) && (bias_h == '0);
  endfunction

  initial begin
    rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = '0;
    s_x = '0; s_valid = 0; dp_ready = 0; dp_valid = 0;
    tick(); tick();
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    chk("rst_coef", coef_zero(), 1);

    // Full load, words 1..48 back to back.
    rst = 0; cfg_start = 1; tick();
    cfg_start = 0;
    chk("load_ready", cfg_ready, 1);
    chk("load_busy", cfg_busy, 1);
    for (int k = 1; k <= 48; k++) begin
      cfg_valid = 1; cfg_data = WIDTH'(k); tick();
      if (k == 1)  chk("wx0_next", weight_x[0], 16'h0001);
      if (k == 47) chk("done_early", cfg_done, 0);
    end
    cfg_valid = 0;
    chk("full_done", cfg_done, 1);
    chk("full_ready", cfg_ready, 0);
    chk("full_busy", cfg_busy, 0);
    chk("wx0", weight_x[0], 16'h0001);
    chk("wx11", weight_x[11], 16'h000c);
    chk("wh0", weight_h[0], 16'h000d);
    chk("bx0", bias_x[0], 16'h0019);
    chk("bh11", bias_h[11], 16'h0030);
    tick();
    chk("full_ready2", cfg_ready, 0);

    // Backpressure: stack never returns, gate closes at 8.
    dp_ready = 1; s_valid = 1; s_x = 16'h1234; #1;
    chk("act_sready", s_ready, 1);
    chk("act_dpx", dp_x_in, 16'h1234);
    chk("act_dpv", dp_x_in_valid, 1);
    for (int k = 0; k < 8; k++) tick();
    chk("bp_inflight8", inflight, 8);
    chk("bp_sready0", s_ready, 0);
    chk("bp_dpv0", dp_x_in_valid, 0);
    dp_valid = 1; tick(); dp_valid = 0;
    chk("bp_inflight7", inflight, 7);
    accs = 0;
    for (int k = 0; k < 4; k++) begin
      #1; accs += int'(dp_x_in_valid); tick();
    end
    chk("bp_one_more", accs, 1);
    chk("bp_inflight8b", inflight, 8);
    dp_ready = 0; s_valid = 1; #1;
    chk("dpready_gate", s_ready, 0);
    dp_ready = 1;

    // Simultaneous accept and return.
    s_valid = 0; dp_valid = 1;
    for (int k = 0; k < 6; k++) tick();
    chk("sim_inflight2", inflight, 2);
    s_valid = 1; tick();
    chk("sim_both", inflight, 2);
    s_valid = 0; tick(); tick();
    chk("sim_zero", inflight, 0);
    chk("sim_noerr", err, 0);
    tick();
    chk("underflow_err", err, 1);
    chk("underflow_inf", inflight, 0);
    dp_valid = 0; tick();
    chk("err_sticky", err, 1);

    // Reload with 3 samples in flight.
    s_valid = 1;
    for (int k = 0; k < 3; k++) tick();
    chk("rl_inflight3", inflight, 3);
    cfg_start = 1; #1;
    chk("rl_start_gate", s_ready, 0);
    tick(); cfg_start = 0;
    chk("drain_busy", cfg_busy, 1);
    chk("drain_done", cfg_done, 1);
    chk("drain_sready", s_ready, 0);
    chk("drain_dpv", dp_x_in_valid, 0);
    s_valid = 0; dp_valid = 1;
    for (int k = 0; k < 3; k++) tick();
    dp_valid = 0;
    chk("drain_inf0", inflight, 0);
    chk("drain_still", cfg_done, 1);
    tick();
    chk("reload_ready", cfg_ready, 1);
    chk("reload_done0", cfg_done, 0);
    chk("reload_keep_wx0", weight_x[0], 16'h0001);
    chk("reload_keep_bh11", bias_h[11], 16'h0030);
    cfg_valid = 1; cfg_data = 16'h7000; tick();
    chk("reload_wx0", weight_x[0], 16'h7000);
    chk("reload_wx1_keep", weight_x[1], 16'h0002);
    cfg_start = 1; cfg_data = 16'h7001; tick(); cfg_start = 0;
    chk("start_in_load", weight_x[1], 16'h7001);

    // Reset after word 20.
    for (int k = 3; k <= 20; k++) begin
      cfg_data = WIDTH'(16'h0100 + k); tick();
    end
    cfg_valid = 0;
    chk("mid_wh7", weight_h[7], 16'h0114);
    rst = 1; #1;
    chk("rst_comb_ready", cfg_ready, 0);
    chk("rst_comb_busy", cfg_busy, 0);
    tick(); rst = 0; #1;
    chk("mid_coef0", coef_zero(), 1);
    chk("mid_done", cfg_done, 0);
    chk("mid_busy", cfg_busy, 0);
    chk("mid_err", err, 0);
    cfg_start = 1; tick(); cfg_start = 0;
    cfg_valid = 1; cfg_data = 16'habcd; tick(); cfg_valid = 0;
    chk("restart_wx0", weight_x[0], 16'habcd);
    chk("restart_wx1", weight_x[1], 16'h0000);

    // Stalled load: valid on even cycles only.
    rst = 1; tick(); rst = 0;
    cfg_start = 1; tick(); cfg_start = 0;
    for (int c = 0; c < 96; c++) begin
      cfg_valid = (c % 2 == 0);
      cfg_data  = WIDTH'(16'h0200 + c/2 + 1);
      tick();
      if (c == 92) chk("stall_done_early", cfg_done, 0);
    end
    cfg_valid = 0;
    chk("stall_done", cfg_done, 1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("st_wx%0d", i), weight_x[i], 64'(16'h0201 + i));
      chk($sformatf("st_wh%0d", i), weight_h[i], 64'(16'h0201 + N + i));
      chk($sformatf("st_bx%0d", i), bias_x[i],   64'(16'h0201 + 2*N + i));
      chk($sformatf("st_bh%0d", i), bias_h[i],   64'(16'h0201 + 3*N + i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
